// File: rtl/unit_sram_cfg_pkg.sv
// unit_sram_cfg_pkg
//   Shared types for the configurable SRAM tile: access-mode encoding of the
//   conf port, the zero-fill / idle FSM states, and a small conf helper.
package unit_sram_cfg_pkg;

    // Aspect-ratio selection carried on the conf port.
    typedef enum logic [1:0] {
        ConfX32  = 2'b00,
        ConfX16  = 2'b01,
        ConfX8   = 2'b10,
        ConfRsvd = 2'b11
    } conf_e;

    // Tile FSM: zero-fill after reset, then accept accesses.
    typedef enum logic {
        StClear = 1'b0,
        StIdle  = 1'b1
    } state_e;

    localparam int unsigned BYTE_W = 8;

    function automatic logic conf_is_rsvd(input logic [1:0] conf);
        return conf_e'(conf) == ConfRsvd;
    endfunction

endpackage

// File: rtl/unit_sram_cfg_lane_sel.sv
// unit_sram_cfg_lane_sel
//   Combinational address/mode decode shared by the write and read paths.
//   Ports:
//     conf      in   access mode (x32/x16/x8/reserved)
//     addr      in   logical address
//     wr_data   in   raw write data; narrow modes take the low lane bits
//     rd_word   in   physical word currently addressed
//     word_idx  out  physical word index
//     byte_en   out  per-byte write enables for the selected lane
//     wr_lane   out  write data replicated into every lane position
//     rd_lane   out  selected lane, right-justified and zero-extended
//     addr_err  out  reserved mode or a nonzero must-be-zero address bit
module unit_sram_cfg_lane_sel
    import unit_sram_cfg_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic [1:0]             conf,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W-1:0]      rd_word,
    output logic [ADDR_W-3:0]      word_idx,
    output logic [DATA_W/8-1:0]    byte_en,
    output logic [DATA_W-1:0]      wr_lane,
    output logic [DATA_W-1:0]      rd_lane,
    output logic                   addr_err
);

    localparam int unsigned NB  = DATA_W / BYTE_W;
    localparam int unsigned W16 = DATA_W / 2;
    localparam int unsigned W8  = DATA_W / 4;
    localparam int unsigned B16 = NB / 2;
    localparam int unsigned B8  = NB / 4;
    localparam int unsigned WW  = ADDR_W - 2;

    always_comb begin
        word_idx = addr[WW-1:0];
        byte_en  = '0;
        wr_lane  = wr_data;
        rd_lane  = '0;
        addr_err = 1'b0;
        unique case (conf_e'(conf))
            ConfX32: begin
                byte_en  = '1;
                addr_err = |addr[ADDR_W-1:ADDR_W-2];
                rd_lane  = rd_word;
            end
            ConfX16: begin
                word_idx = addr[ADDR_W-2:1];
                addr_err = addr[ADDR_W-1];
                // Replicate so whichever half is enabled sees the low lane bits.
                wr_lane  = {2{wr_data[W16-1:0]}};
                for (int unsigned b = 0; b < NB; b++) begin
                    byte_en[b] = ((b / B16) == 32'(addr[0]));
                end
                rd_lane[W16-1:0] = rd_word[32'(addr[0]) * W16 +: W16];
            end
            ConfX8: begin
                word_idx = addr[ADDR_W-1:2];
                wr_lane  = {4{wr_data[W8-1:0]}};
                for (int unsigned b = 0; b < NB; b++) begin
                    byte_en[b] = ((b / B8) == 32'(addr[1:0]));
                end
                rd_lane[W8-1:0] = rd_word[32'(addr[1:0]) * W8 +: W8];
            end
            ConfRsvd: begin
                addr_err = conf_is_rsvd(conf);
            end
        endcase
    end

endmodule

// File: rtl/unit_sram_cfg.sv
// unit_sram_cfg
//   Single-port SRAM tile of 2**(ADDR_W-2) x DATA_W bits, viewed as x32, x16
//   or x8 per access. Optional output register, optional zero-fill after reset.
//   Ports:
//     sram_clk    in   clock, all state on rising edge
//     sram_rst_n  in   asynchronous active-low reset
//     csb         in   chip select, active low
//     web         in   write enable, active low (1 = read)
//     conf        in   access mode, sampled per access
//     addr        in   logical address
//     D_in        in   write data (low lane bits in narrow modes)
//     D_out       out  read data, right-justified, zero-extended; holds between reads
//     rd_valid    out  one-cycle pulse when D_out carries new data
//     ready       out  tile idle and accepting accesses
//     err         out  one-cycle pulse for a rejected access
//   Notes: the DATA_W/4 x8 lane must be whole bytes, so DATA_W is a multiple of 32.
module unit_sram_cfg
    import unit_sram_cfg_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned OUT_REG        = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              sram_clk,
    input  logic              sram_rst_n,
    input  logic              csb,
    input  logic              web,
    input  logic [1:0]        conf,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] D_in,
    output logic [DATA_W-1:0] D_out,
    output logic              rd_valid,
    output logic              ready,
    output logic              err
);

    localparam int unsigned WW     = ADDR_W - 2;
    localparam int unsigned PDEPTH = 2 ** WW;
    localparam int unsigned NB     = DATA_W / BYTE_W;
    localparam state_e      StRst  = (CLEAR_ON_RESET != 0) ? StClear : StIdle;

    // Storage; contents are deliberately not reset.
    logic [DATA_W-1:0] mem [PDEPTH];

    state_e          state_q, state_d;
    logic [WW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            clearing;

    logic [WW-1:0]   word_idx;
    logic [NB-1:0]   byte_en;
    logic [DATA_W-1:0] wr_lane, rd_lane, rd_word;
    logic            addr_err;

    logic            acc_req, acc_ok, acc_rej, wr_en, rd_en;

    logic            err_q;
    logic            s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            state_q   <= StRst;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clearing  = 1'b0;
        ready     = 1'b0;
        unique case (state_q)
            StClear: begin
                clearing  = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (&clr_ptr_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                ready = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------- access decode
    unit_sram_cfg_lane_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lane_sel (
        .conf     (conf),
        .addr     (addr),
        .wr_data  (D_in),
        .rd_word  (rd_word),
        .word_idx (word_idx),
        .byte_en  (byte_en),
        .wr_lane  (wr_lane),
        .rd_lane  (rd_lane),
        .addr_err (addr_err)
    );

    always_comb begin
        acc_req = ~csb;
        acc_ok  = acc_req & ready & ~addr_err;
        acc_rej = acc_req & (~ready | addr_err);
        wr_en   = acc_ok & ~web;
        rd_en   = acc_ok & web;
    end

    // ------------------------------------------------------------- storage
    always_ff @(posedge sram_clk) begin
        if (clearing) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*BYTE_W +: BYTE_W] <= wr_lane[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read sees the array before this edge's write, giving pre-write data
    // for write-after-read and new data for read-after-write.
    assign rd_word = mem[word_idx];

    // ------------------------------------------------------- read pipeline
    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            err_q      <= acc_rej;
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_data_q <= rd_lane;
            end
        end
    end

    assign err = err_q;

    if (OUT_REG != 0) begin : g_out_reg
        logic              out_valid_q;
        logic [DATA_W-1:0] out_data_q;

        always_ff @(posedge sram_clk or negedge sram_rst_n) begin
            if (!sram_rst_n) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= s1_data_q;
                end
            end
        end

        assign D_out    = out_data_q;
        assign rd_valid = out_valid_q;
    end else begin : g_no_out_reg
        assign D_out    = s1_data_q;
        assign rd_valid = s1_valid_q;
    end

endmodule

// File: tb/tb_unit_sram_cfg.sv
// tb_unit_sram_cfg
//   Directed bench for unit_sram_cfg (32-bit, 12-bit address, output register,
//   zero-fill on reset): table of single accesses plus hand-written sequences
//   for zero-fill timing, streaming, read/write ordering and mid-flight reset.
module tb_unit_sram_cfg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;
    localparam int          PD = 1024;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          csb   = 1'b1;
    logic          web   = 1'b1;
    logic [1:0]    conf  = 2'b00;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] din   = '0;
    logic [DW-1:0] dout;
    logic          rd_valid;
    logic          ready;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    unit_sram_cfg #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .OUT_REG        (1),
        .CLEAR_ON_RESET (1)
    ) dut (
        .sram_clk   (clk),
        .sram_rst_n (rst_n),
        .csb        (csb),
        .web        (web),
        .conf       (conf),
        .addr       (addr),
        .D_in       (din),
        .D_out      (dout),
        .rd_valid   (rd_valid),
        .ready      (ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic          csb;
        logic          web;
        logic [1:0]    conf;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          exp_err;
        logic          exp_rv;
        logic [DW-1:0] exp_dout;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csb = 1'b1;
        web = 1'b1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [1:0] cf,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        csb  = c;
        web  = w;
        conf = cf;
        addr = a;
        din  = d;
    endtask

    // Counts edges until ready; must be exactly exp_n with no rd_valid on the way.
    task automatic run_clear(input string tag, input int exp_n);
        int   n;
        logic saw_rv;
        n      = 0;
        saw_rv = 1'b0;
        check({tag, "_ready_low"}, 32'(ready), 32'd0);
        while (ready !== 1'b1 && n < PD + 50) begin
            tick();
            n++;
            if (rd_valid) saw_rv = 1'b1;
        end
        check({tag, "_clear_cycles"}, 32'(n), 32'(exp_n));
        check({tag, "_no_rv"}, 32'(saw_rv), 32'd0);
    endtask

    task automatic apply_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        drive(vecs[i].csb, vecs[i].web, vecs[i].conf, vecs[i].addr, vecs[i].din);
        tick();
        idle();
        check({nm, "_err"}, 32'(err), 32'(vecs[i].exp_err));
        check({nm, "_rv_early"}, 32'(rd_valid), 32'd0);
        tick();
        check({nm, "_rv"}, 32'(rd_valid), 32'(vecs[i].exp_rv));
        check({nm, "_dout"}, dout, vecs[i].exp_dout);
        check({nm, "_err_gone"}, 32'(err), 32'd0);
        tick();
        check({nm, "_rv_gone"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] pat [8];
        logic          saw_rv;

        //            csb   web   conf   addr     din            err   rv    dout
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 12'h3FF, 32'h0,        1'b0, 1'b1, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 12'h005, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 12'h005, 32'h0,        1'b0, 1'b1, 32'hAABB_CCDD};
        vecs[3]  = '{1'b0, 1'b1, 2'd2, 12'h016, 32'h0,        1'b0, 1'b1, 32'h0000_00BB};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 12'h00B, 32'h0,        1'b0, 1'b1, 32'h0000_AABB};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 12'h017, 32'hFFFFFF11, 1'b0, 1'b0, 32'h0000_AABB};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 12'h005, 32'h0,        1'b0, 1'b1, 32'h11BB_CCDD};
        vecs[7]  = '{1'b0, 1'b1, 2'd3, 12'h005, 32'h0,        1'b1, 1'b0, 32'h11BB_CCDD};
        vecs[8]  = '{1'b0, 1'b0, 2'd3, 12'h005, 32'h0,        1'b1, 1'b0, 32'h11BB_CCDD};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 12'h400, 32'hDEADBEEF, 1'b1, 1'b0, 32'h11BB_CCDD};
        vecs[10] = '{1'b0, 1'b0, 2'd1, 12'h800, 32'h0000FFFF, 1'b1, 1'b0, 32'h11BB_CCDD};
        vecs[11] = '{1'b0, 1'b1, 2'd0, 12'h400, 32'h0,        1'b1, 1'b0, 32'h11BB_CCDD};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 12'h000, 32'h0,        1'b0, 1'b1, 32'h0000_0000};
        vecs[13] = '{1'b0, 1'b1, 2'd0, 12'h005, 32'h0,        1'b0, 1'b1, 32'h11BB_CCDD};
        vecs[14] = '{1'b0, 1'b0, 2'd1, 12'h001, 32'hFFFF1234, 1'b0, 1'b0, 32'h11BB_CCDD};
        vecs[15] = '{1'b0, 1'b0, 2'd2, 12'h000, 32'hFFFFFF56, 1'b0, 1'b0, 32'h11BB_CCDD};
        vecs[16] = '{1'b0, 1'b1, 2'd0, 12'h000, 32'h0,        1'b0, 1'b1, 32'h1234_0056};
        vecs[17] = '{1'b0, 1'b1, 2'd1, 12'h000, 32'h0,        1'b0, 1'b1, 32'h0000_0056};
        vecs[18] = '{1'b0, 1'b1, 2'd2, 12'h003, 32'h0,        1'b0, 1'b1, 32'h0000_0012};
        vecs[19] = '{1'b1, 1'b1, 2'd0, 12'h005, 32'h0,        1'b0, 1'b0, 32'h0000_0012};
        vecs[20] = '{1'b0, 1'b1, 2'd1, 12'h801, 32'h0,        1'b1, 1'b0, 32'h0000_0012};
        vecs[21] = '{1'b0, 1'b1, 2'd2, 12'hFFF, 32'h0,        1'b0, 1'b1, 32'h0000_0000};

        for (int k = 0; k < 8; k++) pat[k] = 32'hC0DE_0000 | 32'(k * 32'h0101);

        // Reset values while held in reset.
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_dout", dout, 32'd0);
        check("rst_rv", 32'(rd_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;

        // Zero-fill with an access attempted on edge 4: err pulse, no read.
        repeat (3) tick();
        drive(1'b0, 1'b1, 2'd0, 12'h000, 32'h0);
        tick();
        idle();
        check("clr_access_err", 32'(err), 32'd1);
        tick();
        check("clr_access_err_gone", 32'(err), 32'd0);
        check("clr_access_no_rv", 32'(rd_valid), 32'd0);
        run_clear("clr1", PD - 5);

        for (int i = 0; i < NV; i++) apply_vec(i);

        // Streaming: fill words 0..7, then 8 back-to-back reads.
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 2'd0, 12'(k), pat[k]);
            tick();
        end
        for (int k = 0; k < 11; k++) begin
            if (k < 8) drive(1'b0, 1'b1, 2'd0, 12'(k), 32'h0);
            else idle();
            tick();
            if (k >= 1 && k <= 8) begin
                check($sformatf("stream%0d_rv", k - 1), 32'(rd_valid), 32'd1);
                check($sformatf("stream%0d_dout", k - 1), dout, pat[k-1]);
            end else begin
                check($sformatf("stream_gap%0d_rv", k), 32'(rd_valid), 32'd0);
            end
        end

        // Write, read, overwrite, read on consecutive edges.
        drive(1'b0, 1'b0, 2'd0, 12'h010, 32'h0A0A_0A0A);
        tick();
        drive(1'b0, 1'b1, 2'd0, 12'h010, 32'h0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 12'h010, 32'h5B5B_5B5B);
        tick();
        check("raw_war_rv", 32'(rd_valid), 32'd1);
        check("raw_war_dout", dout, 32'h0A0A_0A0A);
        drive(1'b0, 1'b1, 2'd0, 12'h010, 32'h0);
        tick();
        idle();
        check("raw2_rv_early", 32'(rd_valid), 32'd0);
        tick();
        check("raw2_rv", 32'(rd_valid), 32'd1);
        check("raw2_dout", dout, 32'h5B5B_5B5B);

        // Reset with a read in flight.
        drive(1'b0, 1'b1, 2'd0, 12'h005, 32'h0);
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("rstrd_dout", dout, 32'd0);
        check("rstrd_rv", 32'(rd_valid), 32'd0);
        check("rstrd_ready", 32'(ready), 32'd0);
        tick();
        check("rstrd_rv_after", 32'(rd_valid), 32'd0);
        tick();
        rst_n = 1'b1;

        // Reset again at clear cycle 500.
        saw_rv = 1'b0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (rd_valid) saw_rv = 1'b1;
        end
        check("midclr_ready", 32'(ready), 32'd0);
        check("midclr_no_rv", 32'(saw_rv), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midclr_rst_ready", 32'(ready), 32'd0);
        check("midclr_rst_dout", dout, 32'd0);
        tick();
        rst_n = 1'b1;
        run_clear("clr3", PD);

        // Zero-fill reached previously written words.
        drive(1'b0, 1'b1, 2'd0, 12'h005, 32'h0);
        tick();
        idle();
        tick();
        check("post_clr_rv", 32'(rd_valid), 32'd1);
        check("post_clr_dout", dout, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
